// File: rtl/sha256_w_stream_reader.sv
// -----------------------------------------------------------------------------
// sha256_w_stream_reader
//   Reader side of the pipelined SHA-256 message-schedule memory. It takes a
//   stored schedule window of NWORDS words, packed MSW-first, through a
//   valid/ready handshake. It then streams the window one word per cycle to
//   the compression round core, and tags every word with a round index.
//   There are two slots: a stream slot holding the window being read out, and
//   a pending slot holding the next window. With both, back-to-back windows
//   stream with no idle cycle between them.
//
// Ports
//   CLK          in   clock, rising edge
//   RST          in   asynchronous reset, active low
//   flush        in   synchronous abort of all buffered data
//   block_valid  in   block_in holds a window
//   block_ready  out  reader can take a window (registered)
//   block_in     in   window; word k = block_in[(NWORDS-k)*WORD_W-1 -: WORD_W]
//   w_valid      out  w_out / w_t / w_last valid (registered)
//   w_ready      in   round core accepts the word
//   w_out        out  current schedule word (registered)
//   w_t          out  round index, ROUND_BASE + k mod 2^T_W (registered)
//   w_last       out  high with word k = NWORDS-1 (registered)
//   busy         out  any slot occupied (registered)
// -----------------------------------------------------------------------------
module sha256_w_stream_reader #(
  parameter int WORD_W     = 32,
  parameter int NWORDS     = 13,
  parameter int T_W        = 6,
  parameter int ROUND_BASE = 0
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     flush,
  input  logic                     block_valid,
  output logic                     block_ready,
  input  logic [NWORDS*WORD_W-1:0] block_in,
  output logic                     w_valid,
  input  logic                     w_ready,
  output logic [WORD_W-1:0]        w_out,
  output logic [T_W-1:0]           w_t,
  output logic                     w_last,
  output logic                     busy
);

  localparam int BLK_W = NWORDS * WORD_W;
  localparam int K_W   = $clog2(NWORDS + 1);
  localparam logic [K_W-1:0] K_LAST = K_W'(NWORDS - 1);
  localparam logic [T_W-1:0] T_BASE = T_W'(ROUND_BASE);

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_STREAM = 2'd1,
    ST_FULL   = 2'd2
  } state_t;

  state_t             r_state;
  logic [BLK_W-1:0]   r_stream;   // shifts left one word per transfer, current word on top
  logic [BLK_W-1:0]   r_pend;
  logic [K_W-1:0]     r_k;
  logic [T_W-1:0]     r_t;
  logic               r_last;
  logic               r_valid;
  logic               r_ready;
  logic               r_busy;

  state_t             w_state_nx;
  logic [BLK_W-1:0]   w_stream_nx;
  logic [BLK_W-1:0]   w_pend_nx;
  logic [K_W-1:0]     w_k_nx;
  logic [T_W-1:0]     w_t_nx;
  logic               w_last_nx;
  logic               w_valid_nx;
  logic               w_ready_nx;
  logic               w_busy_nx;

  logic               w_accept;
  logic               w_xfer;
  logic               w_last_xfer;

  assign w_accept    = block_valid & r_ready;
  assign w_xfer      = r_valid & w_ready;
  assign w_last_xfer = w_xfer & r_last;

  // Next-state, slot contents and word counter.
  always_comb begin
    w_state_nx  = r_state;
    w_stream_nx = r_stream;
    w_pend_nx   = r_pend;
    w_k_nx      = r_k;
    w_t_nx      = r_t;

    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_state_nx  = ST_STREAM;
          w_stream_nx = block_in;
          w_k_nx      = '0;
          w_t_nx      = T_BASE;
        end else begin
          w_state_nx  = ST_EMPTY;
        end
      end
      ST_STREAM: begin
        if (w_last_xfer) begin
          if (w_accept) begin
            // The next window arrives exactly as the current one finishes.
            w_state_nx  = ST_STREAM;
            w_stream_nx = block_in;
            w_t_nx      = T_BASE;
          end else begin
            w_state_nx  = ST_EMPTY;
            w_stream_nx = '0;
            w_t_nx      = '0;
          end
          w_k_nx = '0;
        end else begin
          if (w_xfer) begin
            w_stream_nx = r_stream << WORD_W;
            w_k_nx      = r_k + K_W'(1);
            w_t_nx      = r_t + T_W'(1);
          end else begin
            w_stream_nx = r_stream;
          end
          if (w_accept) begin
            w_state_nx = ST_FULL;
            w_pend_nx  = block_in;
          end else begin
            w_state_nx = ST_STREAM;
          end
        end
      end
      ST_FULL: begin
        if (w_last_xfer) begin
          // The pending window moves up with no idle cycle in between.
          w_state_nx  = ST_STREAM;
          w_stream_nx = r_pend;
          w_pend_nx   = '0;
          w_k_nx      = '0;
          w_t_nx      = T_BASE;
        end else if (w_xfer) begin
          w_stream_nx = r_stream << WORD_W;
          w_k_nx      = r_k + K_W'(1);
          w_t_nx      = r_t + T_W'(1);
        end else begin
          w_state_nx  = ST_FULL;
        end
      end
      default: begin
        w_state_nx  = ST_EMPTY;
        w_stream_nx = '0;
        w_pend_nx   = '0;
        w_k_nx      = '0;
        w_t_nx      = '0;
      end
    endcase

    // A flush wins over any accept or transfer seen at the same edge.
    if (flush) begin
      w_state_nx  = ST_EMPTY;
      w_stream_nx = '0;
      w_pend_nx   = '0;
      w_k_nx      = '0;
      w_t_nx      = '0;
    end else begin
      w_state_nx  = w_state_nx;
    end
  end

  // Registered output flags derived from the next state.
  always_comb begin
    w_valid_nx = (w_state_nx != ST_EMPTY);
    w_busy_nx  = (w_state_nx != ST_EMPTY);
    w_last_nx  = w_valid_nx & (w_k_nx == K_LAST);
    // block_ready is held low for one cycle after a flush.
    w_ready_nx = ~flush & (w_state_nx != ST_FULL);
  end

  // State, slot and output registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state  <= ST_EMPTY;
      r_stream <= '0;
      r_pend   <= '0;
      r_k      <= '0;
      r_t      <= '0;
      r_last   <= 1'b0;
      r_valid  <= 1'b0;
      r_ready  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_stream <= w_stream_nx;
      r_pend   <= w_pend_nx;
      r_k      <= w_k_nx;
      r_t      <= w_t_nx;
      r_last   <= w_last_nx;
      r_valid  <= w_valid_nx;
      r_ready  <= w_ready_nx;
      r_busy   <= w_busy_nx;
    end
  end

  assign w_out       = r_stream[BLK_W-1 -: WORD_W];
  assign w_t         = r_t;
  assign w_last      = r_last;
  assign w_valid     = r_valid;
  assign block_ready = r_ready;
  assign busy        = r_busy;

endmodule

// File: tb/tb_sha256_w_stream_reader.sv
module tb_sha256_w_stream_reader;

  localparam int WORD_W = 32;
  localparam int NWORDS = 13;
  localparam int T_W    = 6;
  localparam int BLK_W  = WORD_W * NWORDS;

  logic               CLK;
  logic               RST;
  logic               flush;
  logic               block_valid;
  logic [BLK_W-1:0]   block_in;
  logic               w_ready;

  logic               block_ready, w_valid, w_last, busy;
  logic [WORD_W-1:0]  w_out;
  logic [T_W-1:0]     w_t;

  logic               br16, wv16, wl16, bz16;
  logic [WORD_W-1:0]  wo16;
  logic [T_W-1:0]     wt16;

  logic               br60, wv60, wl60, bz60;
  logic [WORD_W-1:0]  wo60;
  logic [T_W-1:0]     wt60;

  int errors;
  int checks;

  sha256_w_stream_reader #(.WORD_W(WORD_W), .NWORDS(NWORDS), .T_W(T_W), .ROUND_BASE(0)) u_dut (
    .CLK(CLK), .RST(RST), .flush(flush), .block_valid(block_valid), .block_ready(block_ready),
    .block_in(block_in), .w_valid(w_valid), .w_ready(w_ready), .w_out(w_out), .w_t(w_t),
    .w_last(w_last), .busy(busy));

  sha256_w_stream_reader #(.WORD_W(WORD_W), .NWORDS(NWORDS), .T_W(T_W), .ROUND_BASE(16)) u_dut16 (
    .CLK(CLK), .RST(RST), .flush(flush), .block_valid(block_valid), .block_ready(br16),
    .block_in(block_in), .w_valid(wv16), .w_ready(w_ready), .w_out(wo16), .w_t(wt16),
    .w_last(wl16), .busy(bz16));

  sha256_w_stream_reader #(.WORD_W(WORD_W), .NWORDS(NWORDS), .T_W(T_W), .ROUND_BASE(60)) u_dut60 (
    .CLK(CLK), .RST(RST), .flush(flush), .block_valid(block_valid), .block_ready(br60),
    .block_in(block_in), .w_valid(wv60), .w_ready(w_ready), .w_out(wo60), .w_t(wt60),
    .w_last(wl60), .busy(bz60));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] word;
    logic [5:0]  t0;
    logic [5:0]  t16;
    logic [5:0]  t60;
    logic        last;
  } vec_t;

  vec_t tbl [26];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [BLK_W-1:0] mk_win(input logic [31:0] base);
    logic [BLK_W-1:0] w;
    w = '0;
    for (int k = 0; k < NWORDS; k++) w[(NWORDS-k)*WORD_W-1 -: WORD_W] = base + 32'(k);
    return w;
  endfunction

  // Compare the presented word of all three instances with table entry i.
  task automatic chk_vec(input int i);
    chk($sformatf("word[%0d]", i), w_out, tbl[i].word);
    chk($sformatf("t[%0d]", i), {26'd0, w_t}, {26'd0, tbl[i].t0});
    chk($sformatf("last[%0d]", i), {31'd0, w_last}, {31'd0, tbl[i].last});
    chk($sformatf("t16[%0d]", i), {26'd0, wt16}, {26'd0, tbl[i].t16});
    chk($sformatf("t60[%0d]", i), {26'd0, wt60}, {26'd0, tbl[i].t60});
  endtask

  // Called at a negedge; consumes table entries first..last_i, returns at the
  // negedge after the last transfer.
  task automatic run_stream(input int first, input int last_i, input bit stall, input bit gapless);
    int idx;
    int cyc;
    bit held;
    logic [31:0] h_w;
    logic [5:0]  h_t;
    logic        h_l;
    idx  = first;
    cyc  = 0;
    held = 1'b0;
    h_w  = '0;
    h_t  = '0;
    h_l  = 1'b0;
    while (idx <= last_i && cyc < 500) begin
      block_valid = 1'b0;
      if (held) begin
        chk("stall_valid", {31'd0, w_valid}, 32'd1);
        chk("stall_word", w_out, h_w);
        chk("stall_t", {26'd0, w_t}, {26'd0, h_t});
        chk("stall_last", {31'd0, w_last}, {31'd0, h_l});
      end
      if (gapless) chk("gapless_valid", {31'd0, w_valid}, 32'd1);
      w_ready = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (w_valid && w_ready) begin
        chk_vec(idx);
        idx++;
        held = 1'b0;
      end else begin
        held = w_valid;
        h_w  = w_out;
        h_t  = w_t;
        h_l  = w_last;
      end
      @(negedge CLK);
      cyc++;
    end
    if (idx <= last_i) begin
      checks++;
      errors++;
      $display("FAIL stream_timeout: got %0d words expected %0d", idx - first, last_i - first + 1);
    end
  endtask

  int drained;

  initial begin
    errors = 0;
    checks = 0;
    for (int i = 0; i < 26; i++) begin
      tbl[i].word = ((i < 13) ? 32'hA000_0000 : 32'hB000_0000) + 32'(i % 13);
      tbl[i].t0   = 6'(i % 13);
      tbl[i].t16  = 6'(16 + (i % 13));
      tbl[i].t60  = 6'((60 + (i % 13)) % 64);
      tbl[i].last = ((i % 13) == 12);
    end

    RST = 1'b0; flush = 1'b0; block_valid = 1'b0; block_in = '0; w_ready = 1'b0;

    // 1: reset values, then ready after release
    @(negedge CLK);
    @(negedge CLK);
    chk("rst_block_ready", {31'd0, block_ready}, 32'd0);
    chk("rst_w_valid", {31'd0, w_valid}, 32'd0);
    chk("rst_w_out", w_out, 32'd0);
    chk("rst_w_t", {26'd0, w_t}, 32'd0);
    chk("rst_w_last", {31'd0, w_last}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    RST = 1'b1;
    @(negedge CLK);
    chk("rel_block_ready", {31'd0, block_ready}, 32'd1);
    chk("rel_w_valid", {31'd0, w_valid}, 32'd0);
    chk("rel_busy", {31'd0, busy}, 32'd0);

    // 2 + 6: single window, full-rate sink
    block_in = mk_win(32'hA000_0000); block_valid = 1'b1; w_ready = 1'b1;
    @(negedge CLK);
    run_stream(0, 12, 1'b0, 1'b1);
    chk("t2_done_valid", {31'd0, w_valid}, 32'd0);
    chk("t2_done_busy", {31'd0, busy}, 32'd0);
    chk("t2_done_last", {31'd0, w_last}, 32'd0);

    // 3: two windows back to back
    block_in = mk_win(32'hA000_0000); block_valid = 1'b1; w_ready = 1'b0;
    @(negedge CLK);
    chk("t3_ready_stream", {31'd0, block_ready}, 32'd1);
    block_in = mk_win(32'hB000_0000); block_valid = 1'b1; w_ready = 1'b1;
    chk_vec(0);
    @(negedge CLK);
    chk("t3_ready_full", {31'd0, block_ready}, 32'd0);
    chk("t3_busy_full", {31'd0, busy}, 32'd1);
    run_stream(1, 25, 1'b0, 1'b1);
    chk("t3_done_valid", {31'd0, w_valid}, 32'd0);
    chk("t3_done_busy", {31'd0, busy}, 32'd0);

    // 4: random sink stalls
    block_in = mk_win(32'hA000_0000); block_valid = 1'b1; w_ready = 1'b0;
    @(negedge CLK);
    run_stream(0, 12, 1'b1, 1'b0);
    chk("t4_done_valid", {31'd0, w_valid}, 32'd0);

    // 5: flush at k=5 with a pending window and a simultaneous offer
    block_in = mk_win(32'hA000_0000); block_valid = 1'b1; w_ready = 1'b0;
    @(negedge CLK);
    block_in = mk_win(32'hB000_0000); block_valid = 1'b1; w_ready = 1'b1;
    chk_vec(0);
    @(negedge CLK);
    run_stream(1, 4, 1'b0, 1'b1);
    chk_vec(5);
    chk("t5_busy_pre", {31'd0, busy}, 32'd1);
    flush = 1'b1; block_valid = 1'b1; block_in = mk_win(32'hC000_0000); w_ready = 1'b1;
    @(negedge CLK);
    flush = 1'b0;
    chk("t5_flush_valid", {31'd0, w_valid}, 32'd0);
    chk("t5_flush_busy", {31'd0, busy}, 32'd0);
    chk("t5_flush_ready", {31'd0, block_ready}, 32'd0);
    chk("t5_flush_last", {31'd0, w_last}, 32'd0);
    @(negedge CLK);
    chk("t5_ready_back", {31'd0, block_ready}, 32'd1);
    chk("t5_not_taken", {31'd0, w_valid}, 32'd0);
    @(negedge CLK);
    block_valid = 1'b0;
    chk("t5_c0_valid", {31'd0, w_valid}, 32'd1);
    chk("t5_c0_word", w_out, 32'hC000_0000);
    chk("t5_c0_t", {26'd0, w_t}, 32'd0);
    chk("t5_c0_t60", {26'd0, wt60}, 32'd60);
    drained = 0;
    for (int c = 0; c < 60 && busy; c++) begin
      if (w_valid && w_ready) drained++;
      @(negedge CLK);
    end
    chk("t5_drain_count", 32'(drained), 32'd13);
    chk("t5_drain_busy", {31'd0, busy}, 32'd0);

    // Reset asserted mid-window
    block_in = mk_win(32'hA000_0000); block_valid = 1'b1; w_ready = 1'b1;
    @(negedge CLK);
    run_stream(0, 3, 1'b0, 1'b1);
    RST = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, w_valid}, 32'd0);
    chk("mid_rst_word", w_out, 32'd0);
    chk("mid_rst_t", {26'd0, w_t}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_ready", {31'd0, block_ready}, 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk("mid_rel_ready", {31'd0, block_ready}, 32'd1);
    chk("mid_rel_valid", {31'd0, w_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
